// File: rtl/vend_pkg.sv
// vend_pkg: state codes, coin encodings and coin values shared by the vending sequencer.
package vend_pkg;
   typedef enum logic [2:0] {S_IDLE = 3'd0, S_COLLECT = 3'd1, S_VEND = 3'd2, S_CHANGE = 3'd3, S_DONE = 3'd4} state_e;
   typedef enum logic [1:0] {C_PENNY = 2'd0, C_NICKEL = 2'd1, C_DIME = 2'd2, C_QUARTER = 2'd3} coin_e;
   localparam logic [9:0] V_PENNY   = 10'd1;
   localparam logic [9:0] V_NICKEL  = 10'd5;
   localparam logic [9:0] V_DIME    = 10'd10;
   localparam logic [9:0] V_QUARTER = 10'd25;
   function automatic logic [9:0] coin_value(input coin_e c);
      return c == C_QUARTER ? V_QUARTER : c == C_DIME ? V_DIME : c == C_NICKEL ? V_NICKEL : V_PENNY;
   endfunction
endpackage

// File: rtl/vend_sequencer_coin_picker.sv
// coin_picker: greedy choice of the largest coin not exceeding the remaining change.
module coin_picker
   import vend_pkg::*;
(
   input  logic [9:0] remaining,
   output coin_e      pick_type,
   output logic [9:0] pick_value
);
   always_comb begin
      pick_type  = remaining >= V_QUARTER ? C_QUARTER :
                   remaining >= V_DIME    ? C_DIME    :
                   remaining >= V_NICKEL  ? C_NICKEL  : C_PENNY;
      pick_value = coin_value(pick_type);
   end
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin collection, vend pulse and greedy change dispensing for one item sale.
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int unsigned MAX_PAID = 999
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       coin_strobe,
   input  logic [1:0] coin_type,
   input  logic       cancel,
   input  logic [9:0] price,
   input  logic       chg_ready,
   output logic [9:0] paid,
   output logic [9:0] price_q,
   output logic       chg_valid,
   output logic [1:0] chg_type,
   output logic       vend,
   output logic       coin_reject,
   output logic       busy,
   output logic       done,
   output logic [2:0] state
);
   localparam logic [9:0] MAX = 10'(MAX_PAID);
   state_e     state_q, state_d;
   logic [9:0] paid_q, paid_d, price_d, remaining_q, remaining_d, coin_val, pick_value;
   logic       reject_q, reject_d, overflow;
   coin_e      pick_type;
   coin_picker u_picker (.remaining(remaining_q), .pick_type(pick_type), .pick_value(pick_value));
   // Compare against MAX - value so the sum never has to exceed 10 bits.
   assign coin_val = coin_value(coin_e'(coin_type));
   assign overflow = paid_q > MAX - coin_val;
   always_comb begin
      state_d     = state_q;
      paid_d      = paid_q;
      price_d     = price_q;
      remaining_d = remaining_q;
      reject_d    = 1'b0;
      case (state_q)
         S_IDLE:
            if (coin_strobe) begin
               if (price != '0) begin
                  paid_d  = coin_val;
                  price_d = price;
                  state_d = S_COLLECT;
               end else reject_d = 1'b1;
            end
         S_COLLECT:
            if (cancel) begin
               reject_d    = coin_strobe;
               remaining_d = paid_q;
               state_d     = S_CHANGE;
            end else begin
               if (paid_q >= price_q) state_d = S_VEND;
               if (coin_strobe) begin
                  if (overflow) reject_d = 1'b1;
                  else paid_d = paid_q + coin_val;
               end
            end
         S_VEND: begin
            reject_d    = coin_strobe;
            remaining_d = paid_q - price_q;
            state_d     = remaining_d != '0 ? S_CHANGE : S_DONE;
         end
         S_CHANGE: begin
            reject_d = coin_strobe;
            if (chg_ready) begin
               remaining_d = remaining_q - pick_value;
               if (remaining_d == '0) state_d = S_DONE;
            end
         end
         S_DONE: begin
            reject_d = coin_strobe;
            paid_d   = '0;
            price_d  = '0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= S_IDLE;
         paid_q      <= '0;
         price_q     <= '0;
         remaining_q <= '0;
         reject_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         paid_q      <= paid_d;
         price_q     <= price_d;
         remaining_q <= remaining_d;
         reject_q    <= reject_d;
      end
   end
   assign state       = state_q;
   assign paid        = paid_q;
   assign busy        = state_q != S_IDLE;
   assign vend        = state_q == S_VEND;
   assign done        = state_q == S_DONE;
   assign chg_valid   = state_q == S_CHANGE;
   assign chg_type    = chg_valid ? pick_type : C_PENNY;
   assign coin_reject = reject_q;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed and random stimulus checked against a transaction-level reference model.
module tb_vend_sequencer;
   localparam int MAX = 999;
   logic       clk = 1'b0, reset = 1'b1, coin_strobe = 1'b0, cancel = 1'b0, chg_ready = 1'b0;
   logic [1:0] coin_type = '0;
   logic [9:0] price = '0;
   logic [9:0] paid, price_q;
   logic       chg_valid, vend, coin_reject, busy, done;
   logic [1:0] chg_type;
   logic [2:0] state;
   int checks = 0, errors = 0;
   int m_st = 0, m_paid = 0, m_price = 0, m_rej = 0;
   int m_chg[$];
   int xfers[$];
   int refund = 0, vends = 0, dones = 0;
   bit saw_change = 0;

   always #5 clk = ~clk;

   vend_sequencer dut (
      .CLOCK_50(clk), .reset(reset), .coin_strobe(coin_strobe), .coin_type(coin_type),
      .cancel(cancel), .price(price), .chg_ready(chg_ready), .paid(paid), .price_q(price_q),
      .chg_valid(chg_valid), .chg_type(chg_type), .vend(vend), .coin_reject(coin_reject),
      .busy(busy), .done(done), .state(state)
   );

   function automatic int cval(int t);
      return t == 0 ? 1 : t == 1 ? 5 : t == 2 ? 10 : 25;
   endfunction

   function automatic int tcode(int v);
      return v == 1 ? 0 : v == 5 ? 1 : v == 10 ? 2 : 3;
   endfunction

   // Change list as coin counts: quarters, then dimes, nickels and pennies of what is left.
   task automatic plan_change(input int amt);
      int q, d, n, p;
      q = amt / 25; d = (amt % 25) / 10; n = (amt % 25 % 10) / 5; p = amt % 5;
      m_chg.delete();
      repeat (q) m_chg.push_back(25);
      repeat (d) m_chg.push_back(10);
      repeat (n) m_chg.push_back(5);
      repeat (p) m_chg.push_back(1);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      int ns, rej, v;
      ns = m_st; rej = 0; v = cval(int'(coin_type));
      if (!reset && chg_valid && chg_ready) begin
         refund += cval(int'(chg_type));
         xfers.push_back(int'(chg_type));
      end
      if (reset) begin
         ns = 0; m_paid = 0; m_price = 0; m_chg.delete();
      end else case (m_st)
         0: if (coin_strobe) begin
               if (price != 0) begin m_paid = v; m_price = int'(price); ns = 1; end
               else rej = 1;
            end
         1: if (cancel) begin
               rej = int'(coin_strobe); plan_change(m_paid); ns = 3;
            end else begin
               if (m_paid >= m_price) ns = 2;
               if (coin_strobe) begin
                  if (m_paid + v > MAX) rej = 1;
                  else m_paid += v;
               end
            end
         2: begin
               rej = int'(coin_strobe); plan_change(m_paid - m_price);
               ns = m_chg.size() > 0 ? 3 : 4;
            end
         3: begin
               rej = int'(coin_strobe);
               if (chg_ready) begin
                  void'(m_chg.pop_front());
                  if (m_chg.size() == 0) ns = 4;
               end
            end
         default: begin
               rej = int'(coin_strobe); m_paid = 0; m_price = 0; ns = 0;
            end
      endcase
      @(posedge clk);
      #1;
      m_st = ns; m_rej = rej;
      chk("state", 16'(state), 16'(m_st));
      chk("paid", 16'(paid), 16'(m_paid));
      chk("price_q", 16'(price_q), 16'(m_price));
      chk("chg_valid", 16'(chg_valid), 16'(m_st == 3));
      chk("chg_type", 16'(chg_type), 16'(m_st == 3 && m_chg.size() > 0 ? tcode(m_chg[0]) : 0));
      chk("vend", 16'(vend), 16'(m_st == 2));
      chk("coin_reject", 16'(coin_reject), 16'(m_rej));
      chk("busy", 16'(busy), 16'(m_st != 0));
      chk("done", 16'(done), 16'(m_st == 4));
      if (done) dones++;
      if (vend) vends++;
      if (state == 3'd3) saw_change = 1;
   endtask

   task automatic coin(input int t);
      coin_strobe = 1'b1; coin_type = 2'(t);
      step();
      coin_strobe = 1'b0;
   endtask

   task automatic run_done(input int bound);
      int d0;
      d0 = dones;
      for (int i = 0; i < bound && dones == d0; i++) step();
      chk("done_reached", 16'(dones != d0), 16'd1);
   endtask

   task automatic restart();
      reset = 1'b1; step(); reset = 1'b0;
      refund = 0; vends = 0; dones = 0; saw_change = 0; xfers.delete();
   endtask

   initial begin
      step(); step();
      restart();
      // Exact change plus a nickel back; price changes mid-sale are ignored.
      price = 10'd65; chg_ready = 1'b1;
      coin(3); price = 10'd7; coin(3); coin(2); coin(2);
      run_done(12);
      chk("refund_65", 16'(refund), 16'd5);
      chk("vends_65", 16'(vends), 16'd1);
      step();
      restart();
      price = 10'd100;
      coin(3); coin(3); coin(3); coin(3);
      step();
      chk("vend_100", 16'(vend), 16'd1);
      step();
      chk("done_after_vend", 16'(done), 16'd1);
      chk("no_change_100", 16'(saw_change), 16'd0);
      step();
      restart();
      price = 10'd50;
      coin(3); coin(2);
      cancel = 1'b1; step(); cancel = 1'b0;
      run_done(12);
      chk("cancel_vends", 16'(vends), 16'd0);
      chk("cancel_xfers", 16'(xfers.size()), 16'd2);
      if (xfers.size() == 2) begin
         chk("cancel_first", 16'(xfers[0]), 16'd3);
         chk("cancel_second", 16'(xfers[1]), 16'd2);
      end
      step();
      chk("cancel_paid0", 16'(paid), 16'd0);
      restart();
      price = 10'd40; chg_ready = 1'b0;
      coin(3);
      cancel = 1'b1; step(); cancel = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("hold_valid", 16'(chg_valid), 16'd1);
         chk("hold_type", 16'(chg_type), 16'd3);
      end
      chg_ready = 1'b1; step(); chg_ready = 1'b0;
      chk("hold_one_xfer", 16'(xfers.size()), 16'd1);
      chk("hold_done", 16'(done), 16'd1);
      step();
      restart();
      price = 10'd0;
      coin(2);
      chk("nosel_reject", 16'(coin_reject), 16'd1);
      chk("nosel_idle", 16'(state), 16'd0);
      step();
      price = 10'd999; chg_ready = 1'b1;
      repeat (39) coin(3);
      coin(2); coin(1);
      chk("paid_990", 16'(paid), 16'd990);
      coin(3);
      chk("max_reject", 16'(coin_reject), 16'd1);
      chk("max_hold", 16'(paid), 16'd990);
      coin(1); coin(0); coin(0); coin(0); coin(0);
      run_done(6);
      chk("max_vend", 16'(vends), 16'd1);
      step();
      restart();
      price = 10'd40; chg_ready = 1'b0;
      coin(3); coin(3); coin(3);
      step();
      chk("mid_change", 16'(state), 16'd3);
      chk("mid_change_q", 16'(chg_type), 16'd3);
      reset = 1'b1; step(); reset = 1'b0;
      chk("rst_state", 16'(state), 16'd0);
      chk("rst_valid", 16'(chg_valid), 16'd0);
      chk("rst_paid", 16'(paid), 16'd0);
      chg_ready = 1'b1;
      repeat (3) step();
      chk("no_resume", 16'(chg_valid), 16'd0);
      for (int i = 0; i < 2000; i++) begin
         coin_strobe = $urandom_range(0, 3) == 0;
         coin_type   = 2'($urandom_range(0, 3));
         cancel      = $urandom_range(0, 19) == 0;
         chg_ready   = $urandom_range(0, 3) != 0;
         reset       = $urandom_range(0, 99) == 0;
         case ($urandom_range(0, 3))
            0: price = 10'd0;
            1: price = 10'($urandom_range(1, 120));
            2: price = 10'd65;
            default: price = 10'($urandom_range(1, 999));
         endcase
         step();
      end
      coin_strobe = 1'b0; cancel = 1'b0; reset = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter MAX_PAID, default 999, is the maximum accumulated payment in cents.
REQ-002 Port CLOCK_50  input  1  is the sole clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  is a synchronous, active-high reset.
REQ-004 Port coin_strobe  input  1  is a one-cycle pulse marking a debounced coin insertion.
REQ-005 Port coin_type  input  2  gives the coin type, sampled with coin_strobe: 0=penny(1), 1=nickel(5), 2=dime(10), 3=quarter(25).
REQ-006 Port cancel  input  1  is a one-cycle pulse requesting refund.
REQ-007 Port price  input  10  is the selected item price in cents; 0 means no selection.
REQ-008 Port chg_ready  input  1  is the coin hopper ready signal.
REQ-009 Port paid  output  10  is the accumulated cents for the current transaction.
REQ-010 Port price_q  output  10  is the latched transaction price.
REQ-011 Port chg_valid  output  1  is the change-coin request valid signal.
REQ-012 Port chg_type  output  2  is the change-coin type, with the same encoding as coin_type.
REQ-013 Port vend  output  1  is a one-cycle item-release pulse.
REQ-014 Port coin_reject  output  1  is a one-cycle pulse marking a coin that was not accepted.
REQ-015 Port busy  output  1  is high in every state except IDLE.
REQ-016 Port done  output  1  is a one-cycle end-of-transaction pulse.
REQ-017 Port state  output  3  is the current FSM state code.

Function
REQ-018 The FSM SHALL have five states: IDLE, COLLECT, VEND, CHANGE, DONE.
REQ-019 In IDLE, a coin_strobe with price!=0 SHALL latch price_q, set paid to the coin value, and go to COLLECT on the next cycle.
REQ-020 In IDLE, a coin_strobe with price==0 SHALL pulse coin_reject, and paid SHALL stay 0.
REQ-021 In COLLECT, each coin_strobe SHALL add the coin value to paid the following cycle.
- Exception: if paid+value > MAX_PAID, paid holds and coin_reject pulses.
REQ-022 The price input SHALL be ignored outside IDLE; price_q holds for the whole transaction.
REQ-023 COLLECT SHALL go to VEND on the cycle after paid >= price_q is true.
REQ-024 A cancel in COLLECT SHALL go to CHANGE with remaining = paid, and no vend pulse.
REQ-025 Simultaneous cancel and coin_strobe SHALL resolve as: cancel wins, the coin is rejected with coin_reject, and paid is unchanged.
REQ-026 VEND SHALL last exactly one cycle with vend=1.
- It loads remaining = paid - price_q (10-bit, never negative by construction).
- It goes to CHANGE if remaining>0, else to DONE.
REQ-027 In CHANGE, chg_valid=1 and chg_type SHALL be the greedy pick from remaining: >=25 quarter, else >=10 dime, else >=5 nickel, else penny.
REQ-028 A change coin SHALL transfer only on a cycle with chg_valid && chg_ready.
- On transfer, remaining decreases by the coin value.
- chg_type SHALL be stable while chg_valid=1 and chg_ready=0.
REQ-029 CHANGE SHALL go to DONE on the cycle after a transfer that makes remaining 0.
- chg_valid SHALL be 0 in DONE.
REQ-030 DONE SHALL last one cycle with done=1, clear paid and price_q to 0, and return to IDLE.
REQ-031 Coin strobes in VEND, CHANGE and DONE SHALL pulse coin_reject and SHALL not alter paid.
REQ-032 Cancel outside COLLECT SHALL be ignored.
REQ-033 The coin_reject pulse SHALL occur one cycle after the offending strobe.

Reset
REQ-034 Reset SHALL take priority over all other inputs, including mid-CHANGE.
REQ-035 On reset, state=IDLE and paid=0, price_q=0, remaining=0.
REQ-036 On reset, chg_valid=0, chg_type=0, vend=0, coin_reject=0, busy=0, done=0.
REQ-037 A change sequence interrupted by reset SHALL be abandoned and not resumed.

Structure
REQ-038 Package vend_pkg SHALL hold:
- the state enum with codes IDLE=0, COLLECT=1, VEND=2, CHANGE=3, DONE=4;
- coin type codes;
- coin value constants 1/5/10/25.
REQ-039 A combinational sub-module coin_picker SHALL take remaining[9:0] and return the greedy type and value; it SHALL be used by the CHANGE logic.
REQ-040 All arithmetic SHALL be 10-bit unsigned; the block SHALL contain no BCD conversion or display logic.

Verification
REQ-041 price=65, coins Q,Q,D,D, chg_ready=1 -> vend one cycle after paid=70, then one nickel transfer, then done; 5 cents refunded.
REQ-042 price=100, coins Q×4 -> vend, no CHANGE state entered, done one cycle after vend.
REQ-043 price=50, coins Q,D then cancel -> no vend; change Q,D issued in that order; paid=0 after done.
REQ-044 price=40, coin Q, then chg_ready held 0 for 10 cycles during change -> chg_valid and chg_type stay stable; then a 1-cycle ready transfers exactly one coin.
REQ-045 price=0, coin D -> coin_reject, state stays IDLE; price=999, paid=990 plus Q -> reject, paid stays 990.
REQ-046 Reset asserted mid-CHANGE with remaining=35 -> the next cycle shows IDLE, chg_valid=0 and paid=0.
